// File: rtl/mult_seq_alu.sv
// Sequential shift-and-add multiplier: one partial product per clock, product latched on Doutmult.
// Build option: define MULT_SIGNED_EN for two's-complement operands (default build is unsigned).
module mult_seq_alu #(
  parameter int unsigned W       = 3,
  parameter logic [1:0]  MULT_OP = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   Doutmult
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand, mcand_nxt;
  logic [PW-1:0]   acc, acc_nxt;
  logic [PW-1:0]   dout_nxt;
  logic [W-1:0]    mplier, mplier_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            busy_nxt, done_nxt;
  logic [PW-1:0]   ext_a;
  logic [PW-1:0]   pp;

  // Multiplicand widened to the product width according to the build's number format.
`ifdef MULT_SIGNED_EN
  assign ext_a = {{W{A[W-1]}}, A};
`else
  assign ext_a = {{W{1'b0}}, A};
`endif

  assign pp = mcand << count;

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    count_nxt  = count;
    dout_nxt   = Doutmult;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (en && (op == MULT_OP)) begin
          mcand_nxt  = ext_a;
          mplier_nxt = B;
          acc_nxt    = '0;
          count_nxt  = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (en) begin
          if (mplier[count]) begin
`ifdef MULT_SIGNED_EN
            // The multiplier's top bit carries negative weight.
            if (count == LAST) acc_nxt = acc - pp;
            else               acc_nxt = acc + pp;
`else
            acc_nxt = acc + pp;
`endif
          end
          if (count == LAST) state_nxt = DONE;
          else               count_nxt = count + CW'(1);
        end
      end
      DONE: begin
        dout_nxt  = acc;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      Doutmult <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      acc      <= acc_nxt;
      count    <= count_nxt;
      Doutmult <= dout_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // A completion is always followed by at least one IDLE cycle.
  assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
